// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
// UART_RX_PARITY_EN (see uart_rx) decides whether the PARITY state is used.
package uart_pkg;

  localparam int UART_DATA_W          = 8;
  localparam int DEFAULT_CLKS_PER_BIT = 868;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

endpackage

// File: rtl/sync2.sv
// Two-flop synchronizer for a single asynchronous input.
// Both flops load RESET_VAL while reset is high.
module sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= RESET_VAL;
      q    <= RESET_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8N1 frames sampled once at mid-bit, LSB first.
// Define UART_RX_PARITY_EN to add an even-parity bit and the parity_err output.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   rx,
  output logic [UART_DATA_W-1:0] data,
  output logic                   valid,
  output logic                   frame_err,
`ifdef UART_RX_PARITY_EN
  output logic                   parity_err,
`endif
  output logic                   busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam int H     = CLKS_PER_BIT / 2;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(H - 1);

  rx_state_t              state;
  rx_state_t              state_next;
  logic [CNT_W-1:0]       cnt;
  logic [2:0]             bit_idx;
  logic [UART_DATA_W-1:0] shreg;
  logic                   armed;
  logic                   parity_ok;
  logic                   rx_s;
  logic                   bit_done;
  logic                   half_done;

  sync2 #(.RESET_VAL(1'b1)) u_sync_rx (
    .clk   (clk),
    .reset (reset),
    .d     (rx),
    .q     (rx_s)
  );

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:   if (armed && !rx_s) state_next = START;
      START:  if (half_done) state_next = rx_s ? IDLE : DATA;
      DATA: begin
        if (bit_done && bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
          state_next = PARITY;
`else
          state_next = STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (bit_done) state_next = STOP;
`endif
      STOP:   if (bit_done) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != IDLE);
    bit_done  = (cnt == CNT_LAST);
    half_done = (cnt == HALF_LAST);
  end

`ifndef UART_RX_PARITY_EN
  assign parity_ok = 1'b1;
`endif

  // Counter, shift register and output pulses; cnt is cleared on every sample.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      armed     <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_ok  <= 1'b1;
      parity_err <= 1'b0;
`endif
    end else begin
      valid     <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      parity_err <= 1'b0;
`endif
      if (rx_s) armed <= 1'b1;

      case (state)
        IDLE: begin
          cnt     <= '0;
          bit_idx <= '0;
`ifdef UART_RX_PARITY_EN
          parity_ok <= 1'b1;
`endif
        end
        START: cnt <= half_done ? '0 : cnt + 1'b1;
        DATA: begin
          if (bit_done) begin
            shreg   <= {rx_s, shreg[UART_DATA_W-1:1]};
            cnt     <= '0;
            bit_idx <= bit_idx + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (bit_done) begin
            parity_ok <= ~(^shreg ^ rx_s);
            cnt       <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
`endif
        STOP: begin
          if (bit_done) begin
            cnt <= '0;
            if (rx_s && parity_ok) begin
              data  <= shreg;
              valid <= 1'b1;
            end
            frame_err <= ~rx_s;
`ifdef UART_RX_PARITY_EN
            parity_err <= ~parity_ok;
`endif
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: cnt <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at CLKS_PER_BIT=16; parity cases run only
// when UART_RX_PARITY_EN is defined.
module tb_uart_rx;

  localparam int C = 16;
  localparam int H = C / 2;
`ifdef UART_RX_PARITY_EN
  localparam int STOP_OFS = 3 + H + 10 * C;
`else
  localparam int STOP_OFS = 3 + H + 9 * C;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic [7:0] data;
  logic       valid;
  logic       frame_err;
  logic       busy;
`ifdef UART_RX_PARITY_EN
  logic       parity_err;
`endif

  uart_rx #(.CLKS_PER_BIT(C)) dut (
    .clk        (clk),
    .reset      (reset),
    .rx         (rx),
    .data       (data),
    .valid      (valid),
    .frame_err  (frame_err),
`ifdef UART_RX_PARITY_EN
    .parity_err (parity_err),
`endif
    .busy       (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Event monitor, sampled on the falling edge.
  int         v_cnt = 0;
  int         fe_cnt = 0;
  int         pe_cnt = 0;
  int         busy_cnt = 0;
  int         v_cyc[$];
  logic [7:0] v_data[$];

  always @(negedge clk) begin
    if (valid) begin
      v_cnt <= v_cnt + 1;
      v_cyc.push_back(cyc);
      v_data.push_back(data);
    end
    if (frame_err) fe_cnt <= fe_cnt + 1;
`ifdef UART_RX_PARITY_EN
    if (parity_err) pe_cnt <= pe_cnt + 1;
`endif
    if (busy) busy_cnt <= busy_cnt + 1;
  end

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // All stimulus tasks start and end 1 time unit after a rising edge.
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic par, input logic stop,
                            output int p);
    logic [10:0] bits;
    int          n;
`ifdef UART_RX_PARITY_EN
    bits = {stop, par, b, 1'b0};
    n    = 11;
`else
    bits = {1'b0, stop, b, 1'b0};
    n    = 10;
`endif
    p = cyc;
    for (int i = 0; i < n; i++) begin
      rx = bits[i];
      idle(C);
    end
  endtask

  int         p, p2, v0, f0, q0, b0, pe0;
  logic [7:0] mid_byte;

  initial begin
    idle(3);
    check("rst_data", data, 0);
    check("rst_valid", valid, 0);
    check("rst_ferr", frame_err, 0);
    check("rst_busy", busy, 0);
    reset = 1'b0;
    idle(5);

    // 0xA5, good stop bit
    v0 = v_cnt; f0 = fe_cnt; q0 = v_cyc.size();
    send_frame(8'hA5, 1'b0, 1'b1, p);
    idle(10);
    check("a5_valid_cnt", v_cnt - v0, 1);
    check("a5_data", v_data[q0], 8'hA5);
    check("a5_time", v_cyc[q0], p + STOP_OFS);
    check("a5_ferr", fe_cnt - f0, 0);

    // back-to-back 0x00 then 0xFF, no idle gap
    v0 = v_cnt; q0 = v_cyc.size();
    send_frame(8'h00, 1'b0, 1'b1, p);
    send_frame(8'hFF, 1'b1, 1'b1, p2);
    idle(10);
    check("b2b_valid_cnt", v_cnt - v0, 2);
    check("b2b_data0", v_data[q0], 8'h00);
    check("b2b_data1", v_data[q0 + 1], 8'hFF);
    check("b2b_time0", v_cyc[q0], p + STOP_OFS);
    check("b2b_spacing", v_cyc[q0 + 1] - v_cyc[q0], C * (STOP_OFS - 3 - H) / (STOP_OFS - 3 - H) * ((STOP_OFS - 3 - H) / C + 1));
    check("b2b_data_out", data, 8'hFF);

    // 4-cycle low glitch on idle line
    v0 = v_cnt; f0 = fe_cnt; b0 = busy_cnt;
    rx = 1'b0;
    idle(4);
    rx = 1'b1;
    idle(40);
    check("glitch_busy_cycles", busy_cnt - b0, H);
    check("glitch_valid", v_cnt - v0, 0);
    check("glitch_ferr", fe_cnt - f0, 0);
    check("glitch_idle", busy, 0);

    // 0x3C with stop bit 0
    v0 = v_cnt; f0 = fe_cnt;
    send_frame(8'h3C, 1'b0, 1'b0, p);
    rx = 1'b1;
    idle(40);
    check("ferr_cnt", fe_cnt - f0, 1);
    check("ferr_valid", v_cnt - v0, 0);
    check("ferr_data_kept", data, 8'hFF);

    // reset in the middle of data bit 3
    v0 = v_cnt; f0 = fe_cnt;
    mid_byte = 8'hC3;
    rx = 1'b0;
    idle(C);
    for (int i = 0; i < 3; i++) begin
      rx = mid_byte[i];
      idle(C);
    end
    rx = mid_byte[3];
    idle(H);
    reset = 1'b1;
    rx = 1'b1;
    idle(3);
    reset = 1'b0;
    idle(2);
    check("mrst_data", data, 0);
    check("mrst_valid", valid, 0);
    check("mrst_ferr", frame_err, 0);
    check("mrst_busy", busy, 0);
    idle(C);
    check("mrst_no_pulse", (v_cnt - v0) + (fe_cnt - f0), 0);
    v0 = v_cnt; q0 = v_cyc.size();
    send_frame(8'h5A, 1'b0, 1'b1, p);
    rx = 1'b1;
    idle(10);
    check("mrst_next_cnt", v_cnt - v0, 1);
    check("mrst_next_data", v_data[q0], 8'h5A);
    check("mrst_next_time", v_cyc[q0], p + STOP_OFS);

`ifdef UART_RX_PARITY_EN
    // 0x07 has three ones: even parity bit must be 1
    v0 = v_cnt; pe0 = pe_cnt;
    send_frame(8'h07, 1'b0, 1'b1, p);
    idle(10);
    check("par_bad_perr", pe_cnt - pe0, 1);
    check("par_bad_valid", v_cnt - v0, 0);
    v0 = v_cnt; pe0 = pe_cnt; q0 = v_cyc.size();
    send_frame(8'h07, 1'b1, 1'b1, p);
    idle(10);
    check("par_ok_valid", v_cnt - v0, 1);
    check("par_ok_data", v_data[q0], 8'h07);
    check("par_ok_time", v_cyc[q0], p + STOP_OFS);
    check("par_ok_perr", pe_cnt - pe0, 0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
